// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table, frame bit levels, RX FSM states.
// Used by both the RX and TX sides.
package uart_pkg;

    localparam int DIV_W = 13;

    localparam logic [DIV_W-1:0] DIV_9600   = 13'd5207;
    localparam logic [DIV_W-1:0] DIV_19200  = 13'd2603;
    localparam logic [DIV_W-1:0] DIV_38400  = 13'd1301;
    localparam logic [DIV_W-1:0] DIV_57600  = 13'd867;
    localparam logic [DIV_W-1:0] DIV_115200 = 13'd433;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd1:    return DIV_19200;
            3'd2:    return DIV_38400;
            3'd3:    return DIV_57600;
            3'd4:    return DIV_115200;
            default: return DIV_9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the serial line plus falling-edge detector.
// Flops reset to 1 so an idle-high line never looks like a start edge.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], rx_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rx_o   = sync_q[STAGES-1];
    assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver with 3-sample majority vote per bit and break handling.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       Parity_Err,
    output logic       Frame_Err,
    output logic       uart_state
);

    import uart_pkg::*;

    logic rx;
    logic fall;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .rx_i   (Rs232_Rx),
        .rx_o   (rx),
        .fall_o (fall)
    );

    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dr_q, dr_d;
    logic [DIV_W-1:0] half;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       smp_q, smp_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif
    logic             at_s0, at_s1, at_vote, at_end;
    logic             vote;

    // cnt_q counts Clk cycles since the synchronized bit boundary
    assign half    = dr_q >> 1;
    assign at_s0   = (cnt_q == half - 13'd1);
    assign at_s1   = (cnt_q == half);
    assign at_vote = (cnt_q == half + 13'd1);
    assign at_end  = (cnt_q == dr_q);
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx) | (smp_q[1] & rx);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dr_d    = dr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        smp_d   = smp_q;
        armed_d = armed_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        busy_d  = busy_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = at_end ? '0 : cnt_q + 13'd1;
            if (at_s0) smp_d[0] = rx;
            if (at_s1) smp_d[1] = rx;
        end
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx) armed_d = 1'b1;
                if (fall && armed_q) begin
                    // edge was seen one cycle after the synchronized boundary
                    state_d = START;
                    cnt_d   = 13'd1;
                    dr_d    = baud_div(baud_set);
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (at_vote && vote != START_BIT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_vote) shift_d = {vote, shift_q[7:1]};
                if (at_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_vote) par_d = vote ^ (^shift_q);
                if (at_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (at_vote) begin
                    // leave mid-stop-bit so a back-to-back start is caught
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    data_d  = shift_q;
                    ferr_d  = (vote != STOP_BIT);
                    armed_d = (vote == STOP_BIT);
                    busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dr_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            smp_q   <= '0;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dr_q    <= dr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            smp_q   <= smp_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_byte  = data_q;
    assign Rx_Done    = done_q;
    assign Frame_Err  = ferr_q;
    assign uart_state = busy_q;
`ifdef UART_RX_PARITY_EN
    assign Parity_Err = perr_q;
`else
    assign Parity_Err = 1'b0;
`endif

endmodule
